uart_tx_queue: RTL

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_tx_queue.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_queue.sv
// Transmit character queue feeding a UART serializer.
// Circular buffer plus a start/handshake FSM with a busy-wait timeout.
module uart_tx_queue #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  flush,
    input  logic                  tx_busy,
    output logic                  tx_en,
    output logic [7:0]            tx_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic [15:0]           drop_count,
    output logic                  idle
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD      = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    localparam logic [DEPTH_LOG2:0]   LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [1:0]            state_q, state_d;
    logic [1:0]            timer_q, timer_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic [15:0]           drop_q, drop_d;

    logic pop;
    logic push_ok;
    logic push_drop;

    assign full       = (level_q == LVL_FULL);
    assign empty      = (level_q == '0);
    assign level      = level_q;
    assign tx_en      = (state_q == LOAD);
    assign tx_data    = tx_data_q;
    assign drop_count = drop_q;
    assign idle       = empty && (state_q == IDLE) && !tx_busy;

    // Flush overrides both sides: no pop, and a same-cycle push is
    // discarded silently rather than counted as a drop.
    always_comb begin
        pop       = (state_q == IDLE) && enable && !empty && !tx_busy && !flush;
        push_ok   = push && !flush && (!full || pop);
        push_drop = push && !flush && full && !pop;

        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        level_d   = level_q;
        tx_data_d = tx_data_q;
        drop_d    = drop_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + PTR_ONE;
                tx_data_d = mem_q[rd_ptr_q];
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (push_ok && !pop) begin
                level_d = level_q + LVL_ONE;
            end else if (pop && !push_ok) begin
                level_d = level_q - LVL_ONE;
            end
        end

        if (push_drop && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = 2'd0;
        unique case (state_q)
            IDLE: begin
                if (pop) state_d = LOAD;
            end
            LOAD: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A serializer that never raises busy costs this
                // character; the queue moves on rather than stall.
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == 2'd3) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 2'd1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            level_q   <= '0;
            state_q   <= IDLE;
            timer_q   <= 2'd0;
            tx_data_q <= 8'h00;
            drop_q    <= 16'h0000;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            level_q   <= level_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            tx_data_q <= tx_data_d;
            drop_q    <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule
